// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-wide memory port between the icache
// refill path (port 0) and the dcache refill/write-back path (port 1).
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int BLOCK_W  = 1024,
    parameter int OFFSET_W = 7,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               req0,
    input  logic               we0,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [BLOCK_W-1:0] wdata0,
    output logic               done0,

    input  logic               req1,
    input  logic               we1,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [BLOCK_W-1:0] wdata1,
    output logic               done1,

    output logic [BLOCK_W-1:0] rdata,

    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic               mem_ack,
    input  logic [BLOCK_W-1:0] mem_rdata,

    output logic [CNT_W-1:0]   gcnt0,
    output logic [CNT_W-1:0]   gcnt1
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [ADDR_W-1:0] OFFSET_MASK =
        {{(ADDR_W-OFFSET_W){1'b0}}, {OFFSET_W{1'b1}}};

    logic [1:0]         state;
    logic               owner;
    logic               last_owner;

    logic               any_req;
    logic               pick1;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [BLOCK_W-1:0] sel_wdata;

    // On a tie the port that did not win last time is served.
    always_comb begin
        any_req   = req0 | req1;
        pick1     = 1'b0;
        if (req0 && req1)
            pick1 = ~last_owner;
        else
            pick1 = req1;
        sel_we    = pick1 ? we1    : we0;
        sel_addr  = pick1 ? addr1  : addr0;
        sel_wdata = pick1 ? wdata1 : wdata0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rdata      <= '0;
            gcnt0      <= '0;
            gcnt1      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner      <= pick1;
                        last_owner <= pick1;
                        mem_req    <= 1'b1;
                        mem_we     <= sel_we;
                        mem_addr   <= sel_addr & ~OFFSET_MASK;
                        mem_wdata  <= sel_wdata;
                        if (pick1)
                            gcnt1 <= gcnt1 + CNT_W'(1);
                        else
                            gcnt0 <= gcnt0 + CNT_W'(1);
                        state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rdata   <= mem_we ? '0 : mem_rdata;
                        done0   <= ~owner;
                        done1   <= owner;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (instantiated with CNT_W=4 so
// the grant counter wrap is reachable).
module tb_mem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int BLOCK_W  = 1024;
    localparam int OFFSET_W = 7;
    localparam int CNT_W    = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               req0, we0, req1, we1;
    logic [ADDR_W-1:0]  addr0, addr1;
    logic [BLOCK_W-1:0] wdata0, wdata1;
    logic               done0, done1;
    logic [BLOCK_W-1:0] rdata;
    logic               mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0]  mem_addr;
    logic [BLOCK_W-1:0] mem_wdata, mem_rdata;
    logic [CNT_W-1:0]   gcnt0, gcnt1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [BLOCK_W-1:0] pat_a, pat_b;

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .BLOCK_W (BLOCK_W),
        .OFFSET_W(OFFSET_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .done0    (done0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .done1    (done1),
        .rdata    (rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .gcnt0    (gcnt0),
        .gcnt1    (gcnt1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; mem_ack = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
        apply_reset();
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_mem: req=%b we=%b addr=%h, required all 0", mem_req, mem_we, mem_addr);
        end
        checks++;
        if (done0 !== 1'b0 || done1 !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_done: done0=%b done1=%b rdata_lo=%h, required 0", done0, done1, rdata[63:0]);
        end
        checks++;
        if (gcnt0 !== 4'd0 || gcnt1 !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: gcnt0=%0d gcnt1=%0d, required 0 0", gcnt0, gcnt1);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        req0 = 1; we0 = 0; addr0 = 32'h0000_04A5;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0480 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL read_grant: req=%b addr=%h we=%b, required 1 00000480 0", mem_req, mem_addr, mem_we);
        end
        checks++;
        if (gcnt0 !== 4'd1) begin
            errors++;
            $display("FAIL read_gcnt0: got %0d required 1", gcnt0);
        end
        repeat (3) tick();
        mem_ack = 1; mem_rdata = pat_a;
        tick();
        checks++;
        if (done0 !== 1'b1 || done1 !== 1'b0 || rdata !== pat_a || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL read_done: done0=%b done1=%b req=%b rdata_lo=%h, required 1 0 0 %h",
                     done0, done1, mem_req, rdata[63:0], pat_a[63:0]);
        end
        mem_ack = 0; req0 = 0; mem_rdata = '0;
        tick();
        checks++;
        if (done0 !== 1'b0) begin
            errors++;
            $display("FAIL read_done_width: done0=%b one cycle later, required 0", done0);
        end
        tick();
    endtask

    task automatic test_single_write();
        apply_reset();
        req1 = 1; we1 = 1; addr1 = 32'h0000_1FFF; wdata1 = pat_b;
        tick();
        checks++;
        if (mem_addr !== 32'h0000_1F80 || mem_we !== 1'b1 || mem_wdata !== pat_b) begin
            errors++;
            $display("FAIL write_grant: addr=%h we=%b wdata_lo=%h, required 00001f80 1 %h",
                     mem_addr, mem_we, mem_wdata[63:0], pat_b[63:0]);
        end
        checks++;
        if (gcnt1 !== 4'd1 || gcnt0 !== 4'd0) begin
            errors++;
            $display("FAIL write_gcnt: gcnt0=%0d gcnt1=%0d, required 0 1", gcnt0, gcnt1);
        end
        tick();
        mem_ack = 1; mem_rdata = pat_a;
        tick();
        checks++;
        if (done1 !== 1'b1 || done0 !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL write_done: done1=%b done0=%b rdata_lo=%h, required 1 0 0", done1, done0, rdata[63:0]);
        end
        mem_ack = 0; req1 = 0; we1 = 0; mem_rdata = '0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        int g_prev;
        int waited;
        logic [BLOCK_W-1:0] pat;
        rst = 1;
        req0 = 1; we0 = 0; addr0 = 32'h0000_2040;
        req1 = 1; we1 = 0; addr1 = 32'h0000_30FF;
        tick();
        rst = 0;
        g_prev = 0;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (mem_req !== 1'b1 && waited < 10);
            checks++;
            if (mem_req !== 1'b1) begin
                errors++;
                $display("FAIL b2b_timeout: no grant %0d within 10 cycles", k);
            end
            checks++;
            if (mem_addr !== ((k % 2 == 0) ? 32'h0000_2000 : 32'h0000_3080)) begin
                errors++;
                $display("FAIL b2b_order: grant %0d addr=%h, required port %0d", k, mem_addr, k % 2);
            end
            if (k > 0) begin
                checks++;
                if (cyc - g_prev !== 4) begin
                    errors++;
                    $display("FAIL b2b_spacing: grant %0d after %0d cycles, required 4", k, cyc - g_prev);
                end
            end
            g_prev = cyc;
            tick();
            pat = {32{32'hC0DE_0000 + 32'(k)}};
            mem_ack = 1; mem_rdata = pat;
            tick();
            checks++;
            if (done0 !== (k % 2 == 0) || done1 !== (k % 2 == 1) || rdata !== pat) begin
                errors++;
                $display("FAIL b2b_done: k=%0d done0=%b done1=%b rdata_lo=%h, required port %0d %h",
                         k, done0, done1, rdata[63:0], k % 2, pat[63:0]);
            end
            mem_ack = 0;
        end
        req0 = 0; req1 = 0;
        tick();
        tick();
    endtask

    task automatic test_payload_stable();
        apply_reset();
        req0 = 1; we0 = 0; addr0 = 32'h0000_04A5;
        tick();
        addr0 = 32'h1234_0000; we0 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mem_addr !== 32'h0000_0480 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL payload_hold: cycle %0d addr=%h we=%b, required 00000480 0", i, mem_addr, mem_we);
            end
        end
        mem_ack = 1; mem_rdata = pat_b;
        tick();
        checks++;
        if (done0 !== 1'b1 || rdata !== pat_b) begin
            errors++;
            $display("FAIL payload_done: done0=%b rdata_lo=%h, required 1 %h", done0, rdata[63:0], pat_b[63:0]);
        end
        mem_ack = 0; req0 = 0; we0 = 0;
        tick();
        tick();
    endtask

    task automatic test_abort();
        apply_reset();
        mem_ack = 1;
        tick();
        mem_ack = 0;
        tick();
        checks++;
        if (done0 !== 1'b0 || done1 !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL spurious_ack: done0=%b done1=%b req=%b, required 0 0 0", done0, done1, mem_req);
        end
        req1 = 1; we1 = 0; addr1 = 32'h0000_5555;
        tick();
        checks++;
        if (mem_req !== 1'b1 || gcnt1 !== 4'd1 || mem_addr !== 32'h0000_5500) begin
            errors++;
            $display("FAIL abort_grant: req=%b gcnt1=%0d addr=%h, required 1 1 00005500", mem_req, gcnt1, mem_addr);
        end
        tick();
        rst = 1; req1 = 0;
        tick();
        rst = 0;
        checks++;
        if (mem_req !== 1'b0 || gcnt0 !== 4'd0 || gcnt1 !== 4'd0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL abort_reset: req=%b gcnt0=%0d gcnt1=%0d addr=%h, required 0 0 0 0",
                     mem_req, gcnt0, gcnt1, mem_addr);
        end
        mem_ack = 1; mem_rdata = pat_a;
        tick();
        mem_ack = 0;
        checks++;
        if (done0 !== 1'b0 || done1 !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: done0=%b done1=%b req=%b, required 0 0 0", done0, done1, mem_req);
        end
        req0 = 1; we0 = 0; addr0 = 32'h0000_0A00;
        req1 = 1; we1 = 0; addr1 = 32'h0000_0B00;
        tick();
        checks++;
        if (mem_addr !== 32'h0000_0A00 || gcnt0 !== 4'd1 || gcnt1 !== 4'd0) begin
            errors++;
            $display("FAIL abort_tie: addr=%h gcnt0=%0d gcnt1=%0d, required 00000a00 1 0", mem_addr, gcnt0, gcnt1);
        end
        req0 = 0; req1 = 0;
        mem_ack = 1;
        tick();
        mem_ack = 0;
        tick();
        tick();
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        for (int n = 1; n <= 17; n++) begin
            req0 = 1; we0 = 0; addr0 = 32'(n) << 7;
            tick();
            mem_ack = 1; mem_rdata = pat_a;
            tick();
            checks++;
            if (done0 !== 1'b1) begin
                errors++;
                $display("FAIL wrap_done: transaction %0d done0=%b, required 1", n, done0);
            end
            mem_ack = 0; req0 = 0;
            tick();
            if (n == 16) begin
                checks++;
                if (gcnt0 !== 4'd0) begin
                    errors++;
                    $display("FAIL wrap_16: gcnt0=%0d, required 0", gcnt0);
                end
            end
        end
        checks++;
        if (gcnt0 !== 4'd1 || gcnt1 !== 4'd0) begin
            errors++;
            $display("FAIL wrap_17: gcnt0=%0d gcnt1=%0d, required 1 0", gcnt0, gcnt1);
        end
    endtask

    initial begin
        pat_a = {32{32'hA5A5_0001}};
        pat_b = {32{32'h5A5A_B00B}};
        rst = 1;
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_payload_stable();
        test_abort();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
